simd_unit: RTL and testbench
============================

# simd_unit

Small packed-SIMD arithmetic engine with a byte-wide load port and a nibble-wide result stream. Two 64-bit operand vectors, A and B, are loaded one byte per clock. One of four lane-wise operations is applied across either eight 8-bit lanes or sixteen 4-bit lanes. The 64-bit result is streamed out 4 bits per clock. It sits between a narrow host bus and downstream logic that consumes results serially.

## Interface
Parameters:
- none (vector width fixed at 64 bits, 16 load bytes, 16 output nibbles)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- load  in  1  when high, the byte on data_ is captured every clock
- mode  in  4  operation select
- dtype  in  1  lane width: 1 = 8-bit lanes (8 lanes), 0 = 4-bit lanes (16 lanes)
- data_  in  8  load byte
- send  in  1  when high, one result nibble is emitted per clock
- data  out  4  result nibble (registered)

## Operation
- Storage: A[63:0], B[63:0], load pointer lp[3:0], send index si[3:0].
- Load:
  - While load=1, each clock writes data_ to byte lp: lp 0..7 writes A[8·lp +: 8]; lp 8..15 writes B[8·(lp−8) +: 8].
  - lp then increments and wraps 15→0.
  - While load=0, lp is cleared to 0, so every load burst starts at A byte 0.
- Result R[63:0] is combinational from A, B, mode and dtype, computed per lane (lane i uses the same bit slice of A and B). All results are truncated to the lane width with no saturation:
  - mode 0: A+B, modulo lane width.
  - mode 1: A−B, modulo lane width (two's complement).
  - mode 2: A×B, low lane-width bits of the product.
  - mode 3: A XOR B.
  - modes 4–15: R = A (pass-through).
- Send:
  - While send=1 and load=0, each clock does data ← R[4·si +: 4] and si ← si+1, wrapping 15→0. Output is LSB nibble first.
  - While send=0, si is cleared to 0 and data ← 0.
- Simultaneous load=1 and send=1: load wins. data and si hold their values; the byte is written normally.
- mode and dtype are sampled every clock. A change during a send affects the next emitted nibble. Callers hold them stable across a 16-cycle send.

## Timing
- Reset (rst=0, asynchronous): A=0, B=0, lp=0, si=0, data=0. This holds even in the middle of a load or send. After rst rises, the first load byte goes to A byte 0.
- Load latency: a byte present at rising edge k is stored at edge k. A full load takes 16 clocks.
- Send latency: data shows nibble 0 after the first rising edge with send=1, and nibble j after edge j+1.
- A full 64-bit result takes 16 clocks of send. A 17th clock re-emits nibble 0.
- Dropping send for at least one clock restarts the stream at nibble 0.
- Operands persist after load drops. Multiple sends with different modes reuse the same A/B.

## Test plan
- Reset: drive rst=0 mid-load and mid-send. Required: data=0 immediately (asynchronously). A subsequent send with mode=3 and dtype=1 yields all-zero nibbles.
- Load A bytes all 0x13 and B bytes all 0x2E, then mode=0, dtype=1, send 16 clocks. Required: 0x41 per lane, stream 1,4,1,4,… (16 nibbles).
- Same operands, dtype=1:
  - mode=1: 0xE5 per lane, stream 5,E,…
  - mode=2: 0x13×0x2E=0x36A, truncated to 0x6A, stream A,6,…
  - mode=3: 0x3D, stream D,3,…
- Same operands, dtype=0:
  - mode=0: stream 1,3,… (3+E=0x11→1, 1+2=3).
  - mode=2: stream A,2,… (3×E=0x2A→A, 1×2=2).
- Distinct bytes: load A=01,02,…,08 and B=00×8, then mode=4. Required: stream 1,0,2,0,…,8,0. An unknown mode passes A through, which also confirms byte ordering.
- Boundaries:
  - A 17-byte load burst wraps and overwrites A byte 0 with the 17th byte.
  - Asserting load during send freezes data.
  - Holding send for 17 clocks re-emits nibble 0 on the 17th.

Source files
------------

// File: rtl/simd_unit.sv
// Packed-SIMD engine: byte-serial operand load, lane-wise add/sub/mul/xor over
// 8x8-bit or 16x4-bit lanes, result streamed out LSB nibble first.

module simd_lane (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] mode,
    input  logic       dtype,
    output logic [7:0] r
);
    logic [7:0]      add8, sub8, mul8;
    logic [1:0][3:0] add4, sub4, mul4;

    assign add8 = a + b;
    assign sub8 = a - b;
    assign mul8 = a * b;

    // The two nibbles of a byte lane become independent 4-bit lanes when dtype=0
    generate
        for (genvar n = 0; n < 2; n++) begin : g_nib
            assign add4[n] = a[4*n +: 4] + b[4*n +: 4];
            assign sub4[n] = a[4*n +: 4] - b[4*n +: 4];
            assign mul4[n] = a[4*n +: 4] * b[4*n +: 4];
        end
    endgenerate

    always_comb begin
        r = a;
        case (mode)
            4'd0:    r = dtype ? add8 : add4;
            4'd1:    r = dtype ? sub8 : sub4;
            4'd2:    r = dtype ? mul8 : mul4;
            4'd3:    r = a ^ b;
            default: r = a;
        endcase
    end
endmodule

module simd_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] mode,
    input  logic       dtype,
    input  logic [7:0] data_,
    input  logic       send,
    output logic [3:0] data
);
    logic [7:0][7:0]  a_q, b_q, r_byte;
    logic [15:0][3:0] r_nib;
    logic [3:0]       lp, si;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_lane
            simd_lane u_lane (
                .a     (a_q[i]),
                .b     (b_q[i]),
                .mode  (mode),
                .dtype (dtype),
                .r     (r_byte[i])
            );
        end
    endgenerate

    assign r_nib = r_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q  <= '0;
            b_q  <= '0;
            lp   <= '0;
            si   <= '0;
            data <= '0;
        end else begin
            // lp[3] selects the B half; lp[2:0] is the byte within the operand
            if (load) begin
                if (lp[3]) b_q[lp[2:0]] <= data_;
                else       a_q[lp[2:0]] <= data_;
                lp <= lp + 4'd1;
            end else begin
                lp <= '0;
            end
            // load has priority: stream state freezes while a byte is written
            if (!load) begin
                if (send) begin
                    data <= r_nib[si];
                    si   <= si + 4'd1;
                end else begin
                    data <= '0;
                    si   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_simd_unit.sv
// Directed bench for simd_unit: hand-computed result streams per mode/dtype,
// load wrap, load-over-send freeze, stream wrap and asynchronous reset.

module tb_simd_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] mode;
    logic       dtype;
    logic [7:0] data_;
    logic       send;
    logic [3:0] data;

    int n_vec = 0;
    int n_err = 0;

    simd_unit dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .mode  (mode),
        .dtype (dtype),
        .data_ (data_),
        .send  (send),
        .data  (data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // n bytes: 0..7 -> A, 8..15 -> B, beyond that -> x
    task automatic load_ops(input logic [63:0] a, input logic [63:0] b,
                            input int n, input logic [7:0] x);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load = 1'b1;
            send = 1'b0;
            if (i < 8)       data_ = a[8*i +: 8];
            else if (i < 16) data_ = b[8*(i-8) +: 8];
            else             data_ = x;
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    // Collects 16 nibbles; send is left high so the caller may probe the wrap
    task automatic send_stream(input string tag, input logic [3:0] m, input logic d,
                               input logic [63:0] exp);
        logic [63:0] got;
        got = '0;
        @(negedge clk);
        mode  = m;
        dtype = d;
        load  = 1'b0;
        send  = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1;
            got[4*j +: 4] = data;
        end
        chk(tag, got, exp);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        send = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, {60'd0, data}, 64'd0);
    endtask

    initial begin
        rst   = 1'b0;
        load  = 1'b0;
        send  = 1'b0;
        mode  = 4'd0;
        dtype = 1'b1;
        data_ = 8'd0;
        #3;
        chk("reset_data", {60'd0, data}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Uniform operands 0x13 / 0x2E
        load_ops({8{8'h13}}, {8{8'h2E}}, 16, 8'h00);
        send_stream("add8", 4'd0, 1'b1, {8{8'h41}});
        idle("idle_add8");
        send_stream("sub8", 4'd1, 1'b1, {8{8'hE5}});
        idle("idle_sub8");
        send_stream("mul8", 4'd2, 1'b1, {8{8'h6A}});
        idle("idle_mul8");
        send_stream("xor8", 4'd3, 1'b1, {8{8'h3D}});
        idle("idle_xor8");
        send_stream("add4", 4'd0, 1'b0, {8{8'h31}});
        idle("idle_add4");
        send_stream("sub4", 4'd1, 1'b0, {8{8'hF5}});
        idle("idle_sub4");
        send_stream("mul4", 4'd2, 1'b0, {8{8'h2A}});
        idle("idle_mul4");

        // Distinct bytes, unknown mode passes A through
        load_ops(64'h0807060504030201, 64'd0, 16, 8'h00);
        send_stream("pass_a", 4'd4, 1'b1, 64'h0807060504030201);
        idle("idle_pass");

        // 17-byte burst overwrites A byte 0; 17th send clock re-emits nibble 0
        load_ops(64'h8877665544332211, 64'd0, 17, 8'hAA);
        send_stream("load_wrap", 4'd15, 1'b1, 64'h88776655443322AA);
        @(posedge clk);
        #1;
        chk("send_wrap17", {60'd0, data}, 64'hA);
        idle("idle_wrap");

        // Load during send freezes data and the send index
        @(negedge clk);
        mode  = 4'd15;
        dtype = 1'b1;
        send  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_freeze", {60'd0, data}, 64'h2);
        @(negedge clk);
        load  = 1'b1;
        data_ = 8'h55;
        @(posedge clk);
        #1;
        chk("freeze", {60'd0, data}, 64'h2);
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        #1;
        chk("post_freeze", {60'd0, data}, 64'h2);
        @(posedge clk);
        #1;
        chk("post_freeze2", {60'd0, data}, 64'h3);
        idle("idle_freeze");

        // Asynchronous reset mid-send (A byte 0 is now 0x55)
        @(negedge clk);
        mode = 4'd15;
        send = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_send", {60'd0, data}, 64'h5);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_send", {60'd0, data}, 64'd0);

        // Asynchronous reset mid-load
        @(negedge clk);
        send  = 1'b0;
        rst   = 1'b1;
        load  = 1'b1;
        data_ = 8'h77;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_load", {60'd0, data}, 64'd0);
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b1;
        send_stream("rst_xor_zero", 4'd3, 1'b1, 64'd0);
        idle("idle_rst_xor");
        send_stream("rst_a_zero", 4'd15, 1'b1, 64'd0);
        idle("idle_rst_a");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
